user_design_mux: RTL and testbench

- Next-generation user-area wrapper core.
- Multiplexes N_DESIGNS independently wrapped designs onto the shared IO pads and logic-analyser outputs.
- A Wishbone-programmable select register chooses the active design. Every switch runs a safe isolate / reset / release sequence so no pad is ever driven by two designs or by a design coming out of reset.
- Sits directly under user_project_wrapper; each design slot's io_in is broadcast outside this block.

---
 rtl/user_mux_pkg.sv | 20 ++
 rtl/user_design_mux_if.sv | 21 ++
 rtl/user_mux_wb_regs.sv | 70 +++++++
 rtl/user_design_mux.sv | 128 ++++++++++++
 tb/tb_user_design_mux.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/user_mux_pkg.sv
// Shared types and register map for the user-area design multiplexer.
package user_mux_pkg;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_ISOLATE = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

  localparam int SEL_W = 4;

  localparam logic [7:0] REG_SEL    = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;

  localparam int STAT_BUSY_BIT = 4;
  localparam int STAT_ERR_BIT  = 8;
  localparam int SEL_PEND_LSB  = 8;

endpackage

// File: rtl/user_design_mux_if.sv
// Wishbone classic slave bundle between the caravel bus and the design multiplexer.
interface user_design_mux_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/user_mux_wb_regs.sv
// Wishbone register block: SEL and STATUS registers, the requested slot and the sticky error flag.
module user_mux_wb_regs
  import user_mux_pkg::*;
#(
  parameter int          N_DESIGNS = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  user_design_mux_if.slave     wb,
  input  state_e               state,
  input  logic [SEL_W-1:0]     active,
  output logic [SEL_W-1:0]     pending,
  output logic                 err
);

  logic        hit;
  logic        acc;
  logic        wr;
  logic        rd;
  logic [7:0]  offset;
  logic [31:0] rdata;
  logic        sel_valid;
  logic        unused_wb;

  assign hit    = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // The cycle after an ack never accepts, so a held strobe is acked every other cycle.
  assign acc    = hit & ~wb.wbs_ack_o;
  assign wr     = acc & wb.wbs_we_i;
  assign rd     = acc & ~wb.wbs_we_i;
  assign offset = wb.wbs_adr_i[7:0];

  assign sel_valid = ({28'd0, wb.wbs_dat_i[3:0]} < 32'(N_DESIGNS));
  assign unused_wb = ^{wb.wbs_dat_i[31:4], wb.wbs_sel_i[3:1]};

  always_comb begin
    rdata = '0;
    case (offset)
      REG_SEL: begin
        rdata[SEL_W-1:0]                       = active;
        rdata[SEL_PEND_LSB +: SEL_W]           = pending;
      end
      REG_STATUS: begin
        rdata[STAT_ERR_BIT]  = err;
        rdata[STAT_BUSY_BIT] = (state != ST_ACTIVE);
        rdata[1:0]           = state;
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
      pending      <= '0;
      err          <= 1'b0;
    end else begin
      wb.wbs_ack_o <= acc;
      wb.wbs_dat_o <= rd ? rdata : '0;
      if (wr && offset == REG_SEL && wb.wbs_sel_i[0]) begin
        if (sel_valid) pending <= wb.wbs_dat_i[SEL_W-1:0];
        else           err     <= 1'b1;
      end else if (rd && offset == REG_STATUS) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/user_design_mux.sv
// Multiplexes N wrapped designs onto the shared pads and LA bus, with an
// isolate / reset / release sequence on every change of the selected slot.
module user_design_mux
  import user_mux_pkg::*;
#(
  parameter int          N_DESIGNS    = 4,
  parameter int          IO_W         = 38,
  parameter int          LA_W         = 64,
  parameter int          GUARD_CYCLES = 4,
  parameter int          RST_CYCLES   = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  user_design_mux_if.slave            wb,
  input  logic [N_DESIGNS*IO_W-1:0]   des_io_out,
  input  logic [N_DESIGNS*IO_W-1:0]   des_io_oeb,
  input  logic [N_DESIGNS*LA_W-1:0]   des_la_out,
  output logic [N_DESIGNS-1:0]        des_rst_o,
  output logic [IO_W-1:0]             io_out,
  output logic [IO_W-1:0]             io_oeb,
  output logic [LA_W-1:0]             la_data_out,
  output logic [2:0]                  user_irq
);

  localparam int CNT_MAX = (GUARD_CYCLES > RST_CYCLES) ? GUARD_CYCLES : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RST_CYCLES - 1);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SEL_W-1:0] active, active_nxt;
  logic [SEL_W-1:0] pending;
  logic             err;
  logic             switch_done;
  logic             slot_running;
  logic             slot_driving;

  user_mux_wb_regs #(
    .N_DESIGNS (N_DESIGNS),
    .BASE_ADDR (BASE_ADDR)
  ) u_regs (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .wb      (wb),
    .state   (state),
    .active  (active),
    .pending (pending),
    .err     (err)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state  <= ST_INIT;
      cnt    <= RST_LOAD;
      active <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      active <= active_nxt;
    end
  end

  // Every state transition reloads the counter for the state being entered.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = (cnt != '0) ? cnt - 1'b1 : cnt;
    active_nxt  = active;
    switch_done = 1'b0;
    case (state)
      ST_INIT: begin
        if (cnt == '0) begin
          state_nxt = ST_ACTIVE;
          cnt_nxt   = '0;
        end
      end
      ST_ACTIVE: begin
        if (pending != active) begin
          state_nxt = ST_ISOLATE;
          cnt_nxt   = GUARD_LOAD;
        end
      end
      ST_ISOLATE: begin
        if (cnt == '0) begin
          state_nxt  = ST_HOLD;
          cnt_nxt    = RST_LOAD;
          active_nxt = pending;
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          state_nxt   = ST_ACTIVE;
          cnt_nxt     = '0;
          switch_done = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_INIT;
        cnt_nxt   = RST_LOAD;
      end
    endcase
  end

  // The old slot keeps running through ISOLATE but only owns the pads while ACTIVE.
  assign slot_running = (state == ST_ACTIVE) || (state == ST_ISOLATE);
  assign slot_driving = (state == ST_ACTIVE);

  always_comb begin
    des_rst_o   = '1;
    io_out      = '0;
    io_oeb      = '1;
    la_data_out = '0;
    for (int k = 0; k < N_DESIGNS; k++) begin
      if (active == SEL_W'(k)) begin
        if (slot_running) des_rst_o[k] = 1'b0;
        if (slot_driving) begin
          io_out      = des_io_out[k*IO_W +: IO_W];
          io_oeb      = des_io_oeb[k*IO_W +: IO_W];
          la_data_out = des_la_out[k*LA_W +: LA_W];
        end
      end
    end
  end

  assign user_irq = {2'b00, switch_done};

endmodule

// File: tb/tb_user_design_mux.sv
// Directed bench for user_design_mux: register table plus hand-sequenced slot switches.
module tb_user_design_mux;

  localparam int          N     = 4;
  localparam int          IO_W  = 38;
  localparam int          LA_W  = 64;
  localparam int          GUARD = 4;
  localparam int          RSTC  = 16;
  localparam logic [31:0] BASE  = 32'h3000_0000;

  localparam int M_OFF = 0;
  localparam int M_ACT = 1;
  localparam int M_ISO = 2;

  localparam logic [31:0] A_SEL    = BASE + 32'h00;
  localparam logic [31:0] A_STATUS = BASE + 32'h04;

  logic                  clk;
  logic                  rst;
  logic [N*IO_W-1:0]     des_io_out;
  logic [N*IO_W-1:0]     des_io_oeb;
  logic [N*LA_W-1:0]     des_la_out;
  logic [N-1:0]          des_rst_o;
  logic [IO_W-1:0]       io_out;
  logic [IO_W-1:0]       io_oeb;
  logic [LA_W-1:0]       la_data_out;
  logic [2:0]            user_irq;

  int n_cmp;
  int n_bad;

  user_design_mux_if wb ();

  user_design_mux #(
    .N_DESIGNS    (N),
    .IO_W         (IO_W),
    .LA_W         (LA_W),
    .GUARD_CYCLES (GUARD),
    .RST_CYCLES   (RSTC),
    .BASE_ADDR    (BASE)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wb          (wb),
    .des_io_out  (des_io_out),
    .des_io_oeb  (des_io_oeb),
    .des_la_out  (des_la_out),
    .des_rst_o   (des_rst_o),
    .io_out      (io_out),
    .io_oeb      (io_oeb),
    .la_data_out (la_data_out),
    .user_irq    (user_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IO_W-1:0] io_pat(int k);
    return {6'(k + 1), 32'(32'hA5A5_0000 + k)};
  endfunction

  function automatic logic [IO_W-1:0] oeb_pat(int k);
    return {6'(k), 32'(32'h0F0F_0000 ^ k)};
  endfunction

  function automatic logic [LA_W-1:0] la_pat(int k);
    return {32'(32'hC0DE_0000 + k), 32'(~k)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_pads(input string name, input int mode, input int slot, input bit irq);
    logic [N-1:0]    e_rst;
    logic [IO_W-1:0] e_io;
    logic [IO_W-1:0] e_oeb;
    logic [LA_W-1:0] e_la;
    e_rst = '1;
    e_io  = '0;
    e_oeb = '1;
    e_la  = '0;
    if (mode != M_OFF) e_rst[slot] = 1'b0;
    if (mode == M_ACT) begin
      e_io  = io_pat(slot);
      e_oeb = oeb_pat(slot);
      e_la  = la_pat(slot);
    end
    chk({name, " des_rst"}, 64'(des_rst_o), 64'(e_rst));
    chk({name, " io_out"},  64'(io_out),    64'(e_io));
    chk({name, " io_oeb"},  64'(io_oeb),    64'(e_oeb));
    chk({name, " la"},      la_data_out,    e_la);
    chk({name, " irq"},     64'(user_irq),  {61'd0, 2'b00, irq});
  endtask

  // Checks n consecutive cycles at the falling edge; irq expected only on the last one.
  task automatic expect_n(input string name, input int mode, input int slot, input int n,
                          input bit irq_last);
    for (int i = 0; i < n; i++) begin
      chk_pads(name, mode, slot, irq_last && (i == n - 1));
      @(negedge clk);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic exp_ack, output logic [31:0] rd);
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_adr_i = adr;
    wb.wbs_dat_i = dat;
    wb.wbs_sel_i = sel;
    @(posedge clk);
    @(negedge clk);
    chk("wb ack", 64'(wb.wbs_ack_o), 64'(exp_ack));
    rd = wb.wbs_dat_o;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    @(negedge clk);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] rd;
    wb_xfer(1'b1, adr, dat, 4'hF, 1'b1, rd);
  endtask

  task automatic wb_read_chk(input string name, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    wb_xfer(1'b0, adr, 32'd0, 4'hF, 1'b1, rd);
    chk(name, 64'(rd), 64'(exp));
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [31:0] rd;
    n_cmp = 0;
    n_bad = 0;

    vecs[0]  = '{1'b1, A_SEL,         32'h0000_0007, 4'hF, 32'h0};
    vecs[1]  = '{1'b0, A_SEL,         32'h0,         4'hF, 32'h0000_0202};
    vecs[2]  = '{1'b0, A_STATUS,      32'h0,         4'hF, 32'h0000_0101};
    vecs[3]  = '{1'b0, A_STATUS,      32'h0,         4'hF, 32'h0000_0001};
    vecs[4]  = '{1'b1, A_STATUS,      32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[5]  = '{1'b0, A_STATUS,      32'h0,         4'hF, 32'h0000_0001};
    vecs[6]  = '{1'b0, BASE + 32'h08, 32'h0,         4'hF, 32'h0};
    vecs[7]  = '{1'b1, A_SEL,         32'h0000_0001, 4'hE, 32'h0};
    vecs[8]  = '{1'b0, A_SEL,         32'h0,         4'hF, 32'h0000_0202};
    vecs[9]  = '{1'b1, A_SEL,         32'h0000_0002, 4'hF, 32'h0};
    vecs[10] = '{1'b0, A_STATUS,      32'h0,         4'hF, 32'h0000_0001};

    for (int k = 0; k < N; k++) begin
      des_io_out[k*IO_W +: IO_W] = io_pat(k);
      des_io_oeb[k*IO_W +: IO_W] = oeb_pat(k);
      des_la_out[k*LA_W +: LA_W] = la_pat(k);
    end
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_adr_i = '0;
    wb.wbs_dat_i = '0;
    wb.wbs_sel_i = '0;
    rst = 1'b1;

    // Reset values and the initial INIT sequence onto slot 0.
    @(negedge clk);
    @(negedge clk);
    chk_pads("reset", M_OFF, 0, 1'b0);
    chk("reset ack", 64'(wb.wbs_ack_o), 64'd0);
    chk("reset dat", 64'(wb.wbs_dat_o), 64'd0);
    rst = 1'b0;
    expect_n("init", M_OFF, 0, RSTC, 1'b0);
    expect_n("act0", M_ACT, 0, 2, 1'b0);
    wb_read_chk("status after init", A_STATUS, 32'h0000_0001);

    // Switch 0 -> 2.
    wb_write(A_SEL, 32'd2);
    expect_n("iso 0->2", M_ISO, 0, GUARD, 1'b0);
    expect_n("hold 0->2", M_OFF, 0, RSTC, 1'b1);
    expect_n("act2", M_ACT, 2, 1, 1'b0);
    wb_read_chk("sel after 0->2", A_SEL, 32'h0000_0202);

    // Register table while slot 2 stays active.
    for (int i = 0; i < 11; i++) begin
      wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, 1'b1, rd);
      if (!vecs[i].we) chk($sformatf("tbl%0d rdata", i), 64'(rd), 64'(vecs[i].exp_rd));
      chk_pads($sformatf("tbl%0d", i), M_ACT, 2, 1'b0);
    end
    expect_n("act2 idle", M_ACT, 2, 3, 1'b0);

    // SEL=1, then SEL=3 written while holding in reset.
    wb_write(A_SEL, 32'd1);
    expect_n("iso 2->1", M_ISO, 2, GUARD, 1'b0);
    wb_write(A_SEL, 32'd3);
    expect_n("hold 2->1", M_OFF, 1, RSTC - 2, 1'b1);
    expect_n("act1 window", M_ACT, 1, 1, 1'b0);
    expect_n("iso 1->3", M_ISO, 1, GUARD, 1'b0);
    expect_n("hold 1->3", M_OFF, 3, RSTC, 1'b1);
    expect_n("act3", M_ACT, 3, 1, 1'b0);
    wb_read_chk("sel after 1->3", A_SEL, 32'h0000_0303);

    // Back to slot 0, then reset in the middle of a 0->2 switch.
    wb_write(A_SEL, 32'd0);
    expect_n("iso 3->0", M_ISO, 3, GUARD, 1'b0);
    expect_n("hold 3->0", M_OFF, 0, RSTC, 1'b1);
    expect_n("act0 again", M_ACT, 0, 1, 1'b0);
    wb_write(A_SEL, 32'd2);
    expect_n("iso before rst", M_ISO, 0, 2, 1'b0);
    rst = 1'b1;
    #1;
    chk_pads("async rst", M_OFF, 0, 1'b0);
    chk("async rst ack", 64'(wb.wbs_ack_o), 64'd0);
    @(negedge clk);
    @(negedge clk);
    chk_pads("rst held", M_OFF, 0, 1'b0);
    rst = 1'b0;
    expect_n("reinit", M_OFF, 0, RSTC, 1'b0);
    expect_n("act0 reinit", M_ACT, 0, 2, 1'b0);
    wb_read_chk("sel after rst", A_SEL, 32'h0000_0000);

    // Out-of-range address never acks.
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_adr_i = BASE + 32'h100;
    wb.wbs_sel_i = 4'hF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("miss ack %0d", i), 64'(wb.wbs_ack_o), 64'd0);
    end

    // Held strobe on SEL acks every other cycle.
    wb.wbs_adr_i = A_SEL;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("held ack %0d", i), 64'(wb.wbs_ack_o), 64'(i % 2));
      @(negedge clk);
    end
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    @(negedge clk);
    expect_n("act0 final", M_ACT, 0, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
